// File: rtl/watch_display_scan.sv
// rtl/watch_display_scan.sv - six-digit multiplexed seven-segment scanner for the watch BCD outputs
module watch_display_scan #(
    parameter int SCAN_DIV     = 4,
    parameter int BLINK_FRAMES = 8,
    parameter bit LZB          = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] sec_lsb,
    input  logic [3:0] sec_msb,
    input  logic [3:0] min_lsb,
    input  logic [3:0] min_msb,
    input  logic [3:0] hr_lsb,
    input  logic [3:0] hr_msb,
    input  logic       set,
    output logic [6:0] seg,
    output logic [5:0] dig_en,
    output logic       colon,
    output logic       err
);
    localparam int PW = $clog2(SCAN_DIV);
    localparam int FW = $clog2(BLINK_FRAMES + 1);

    logic [PW-1:0]   pre;
    logic [2:0]      idx;
    logic [FW-1:0]   frame_cnt;
    logic            blink_phase;
    logic [5:0][3:0] shadow;

    logic            pre_last;
    logic            frame_end;
    logic            load;
    logic            in_bad;
    logic            blank;
    logic [3:0]      cur;
    logic [5:0][3:0] in_digits;

    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'd0:    decode = 7'h3F;
            4'd1:    decode = 7'h06;
            4'd2:    decode = 7'h5B;
            4'd3:    decode = 7'h4F;
            4'd4:    decode = 7'h66;
            4'd5:    decode = 7'h6D;
            4'd6:    decode = 7'h7D;
            4'd7:    decode = 7'h07;
            4'd8:    decode = 7'h7F;
            4'd9:    decode = 7'h6F;
            default: decode = 7'h40;
        endcase
    endfunction

    assign in_digits = {hr_msb, hr_lsb, min_msb, min_lsb, sec_msb, sec_lsb};
    assign pre_last  = (pre == PW'(SCAN_DIV - 1));
    assign frame_end = pre_last && (idx == 3'd5);
    // Set mode follows the inputs live so the user sees edits immediately.
    assign load      = set || frame_end;
    assign in_bad    = (sec_lsb > 4'd9) || (sec_msb > 4'd9) || (min_lsb > 4'd9) ||
                       (min_msb > 4'd9) || (hr_lsb > 4'd9) || (hr_msb > 4'd9);

    always_comb begin
        cur = shadow[0];
        case (idx)
            3'd0:    cur = shadow[0];
            3'd1:    cur = shadow[1];
            3'd2:    cur = shadow[2];
            3'd3:    cur = shadow[3];
            3'd4:    cur = shadow[4];
            3'd5:    cur = shadow[5];
            default: cur = shadow[0];
        endcase
    end

    assign blank = (set && blink_phase) ||
                   (LZB && (idx == 3'd5) && (shadow[5] == 4'd0));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre         <= '0;
            idx         <= 3'd0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
            shadow      <= '0;
            seg         <= 7'h00;
            dig_en      <= 6'h00;
            colon       <= 1'b0;
            err         <= 1'b0;
        end else begin
            pre <= pre_last ? '0 : pre + 1'b1;
            if (pre_last) begin
                idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
            end
            if (frame_end) begin
                if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
                    frame_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
            if (load) begin
                shadow <= in_digits;
                if (in_bad) begin
                    err <= 1'b1;
                end
            end
            // seg is always decoded; blanking acts only through dig_en.
            seg    <= decode(cur);
            dig_en <= blank ? 6'h00 : (6'b000001 << idx);
            colon  <= ~shadow[0][0];
        end
    end
endmodule

// File: tb/tb_watch_display_scan.sv
// tb/tb_watch_display_scan.sv - scoreboard bench for watch_display_scan
module tb_watch_display_scan;
    localparam int SD = 4;
    localparam int BF = 8;
    localparam int FL = 6 * SD;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] din [6];
    logic       set = 1'b0;
    logic [6:0] seg;
    logic [5:0] dig_en;
    logic       colon;
    logic       err;

    typedef struct packed {
        logic [5:0] dig;
        logic [6:0] seg;
        logic       colon;
        logic       err;
    } exp_t;

    exp_t       sb [$];
    logic [3:0] m_sh [6];
    logic       m_err;
    int         cyc;
    int         total = 0;
    int         bad = 0;

    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

    watch_display_scan #(.SCAN_DIV(SD), .BLINK_FRAMES(BF), .LZB(1'b1)) dut (
        .clk(clk), .reset_n(reset_n),
        .sec_lsb(din[0]), .sec_msb(din[1]), .min_lsb(din[2]),
        .min_msb(din[3]), .hr_lsb(din[4]), .hr_msb(din[5]),
        .set(set), .seg(seg), .dig_en(dig_en), .colon(colon), .err(err)
    );

    always #5 clk = ~clk;

    task automatic set_time(input int h, input int m, input int s);
        din[5] = 4'(h / 10); din[4] = 4'(h % 10);
        din[3] = 4'(m / 10); din[2] = 4'(m % 10);
        din[1] = 4'(s / 10); din[0] = 4'(s % 10);
    endtask

    task automatic model_reset();
        cyc = 0;
        m_err = 1'b0;
        for (int i = 0; i < 6; i++) m_sh[i] = 4'd0;
        sb.delete();
    endtask

    // Expected outputs derived from the absolute cycle count since reset.
    task automatic step(input string tag);
        exp_t e;
        exp_t got;
        int   ix;
        bit   bnd;
        bit   ph;
        ix  = (cyc / SD) % 6;
        bnd = (cyc % FL) == FL - 1;
        ph  = ((cyc / FL) / BF) % 2 == 1;
        e.seg   = seg_tab[m_sh[ix]];
        e.dig   = ((set && ph) || (ix == 5 && m_sh[5] == 4'd0)) ? 6'h00 : (6'b000001 << ix);
        e.colon = ~m_sh[0][0];
        if (set || bnd) begin
            for (int i = 0; i < 6; i++) begin
                m_sh[i] = din[i];
                if (din[i] > 4'd9) m_err = 1'b1;
            end
        end
        e.err = m_err;
        sb.push_back(e);
        cyc++;
        @(posedge clk);
        #1;
        got = sb.pop_front();
        total++;
        if (dig_en !== got.dig) begin
            bad++;
            $display("FAIL %s cyc=%0d dig_en got=%b want=%b", tag, cyc, dig_en, got.dig);
        end
        total++;
        if (seg !== got.seg) begin
            bad++;
            $display("FAIL %s cyc=%0d seg got=%h want=%h", tag, cyc, seg, got.seg);
        end
        total++;
        if (colon !== got.colon) begin
            bad++;
            $display("FAIL %s cyc=%0d colon got=%b want=%b", tag, cyc, colon, got.colon);
        end
        total++;
        if (err !== got.err) begin
            bad++;
            $display("FAIL %s cyc=%0d err got=%b want=%b", tag, cyc, err, got.err);
        end
    endtask

    task automatic run_to_boundary(input string tag);
        while (cyc % FL != 0) step(tag);
    endtask

    task automatic check_zero(input string tag);
        total++;
        if ({seg, dig_en, colon, err} !== 15'h0) begin
            bad++;
            $display("FAIL %s outputs got=%h/%b/%b/%b want=0", tag, seg, dig_en, colon, err);
        end
    endtask

    task automatic test_reset();
        set_time(3, 45, 53);
        reset_n = 1'b0;
        #12;
        check_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_first_frame();
        step("first");
        total++;
        if (dig_en !== 6'b000001 || seg !== 7'h3F) begin
            bad++;
            $display("FAIL first_edge got=%b/%h want=000001/3f", dig_en, seg);
        end
        while (cyc < 24) step("first");
        step("frame2");
        total++;
        if (dig_en !== 6'b000001 || seg !== 7'h4F || colon !== 1'b0) begin
            bad++;
            $display("FAIL frame2_d0 got=%b/%h/%b want=000001/4f/0", dig_en, seg, colon);
        end
        while (cyc < 29) step("frame2");
        total++;
        if (dig_en !== 6'b000010 || seg !== 7'h6D) begin
            bad++;
            $display("FAIL frame2_d1 got=%b/%h want=000010/6d", dig_en, seg);
        end
        while (cyc < 45) step("frame2");
        total++;
        if (dig_en !== 6'b000000 || seg !== 7'h3F) begin
            bad++;
            $display("FAIL frame2_lzb got=%b/%h want=000000/3f", dig_en, seg);
        end
        run_to_boundary("frame2");
    endtask

    task automatic test_midframe();
        repeat (10) step("mid");
        din[0] = 4'd4;
        run_to_boundary("mid");
        step("mid");
        total++;
        if (seg !== 7'h66 || colon !== 1'b1) begin
            bad++;
            $display("FAIL mid_update got=%h/%b want=66/1", seg, colon);
        end
        run_to_boundary("mid");
    endtask

    task automatic test_no_blank();
        set_time(23, 59, 55);
        run_to_boundary("noblank");
        repeat (FL) step("noblank");
        for (int k = 0; k < FL; k++) begin
            step("noblank");
            total++;
            if (dig_en !== (6'b000001 << (k / SD))) begin
                bad++;
                $display("FAIL scan_order k=%0d got=%b", k, dig_en);
            end
            if (k == 17 && seg !== 7'h4F) begin
                bad++;
                $display("FAIL hr_lsb_seg got=%h want=4f", seg);
            end
            if (k == 21 && seg !== 7'h5B) begin
                bad++;
                $display("FAIL hr_msb_seg got=%h want=5b", seg);
            end
        end
    endtask

    task automatic test_set_blink();
        int off_cnt = 0;
        int on_cnt = 0;
        set_time(6, 58, 55);
        repeat (7) step("set");
        set = 1'b1;
        for (int k = 0; k < 20 * FL; k++) begin
            if (k % 37 == 0) din[0] = 4'(k % 10);
            step("set");
            if (dig_en == 6'h00) off_cnt++;
            else on_cnt++;
        end
        total++;
        if (off_cnt < 8 * FL || on_cnt < 4 * FL) begin
            bad++;
            $display("FAIL set_blink off=%0d on=%0d", off_cnt, on_cnt);
        end
        set = 1'b0;
        din[0] = 4'd1;
        repeat (5) step("set_fall");
        run_to_boundary("set_fall");
        repeat (FL) step("set_fall");
    endtask

    task automatic test_err();
        set_time(12, 34, 56);
        run_to_boundary("err");
        repeat (FL - 1) step("err");
        din[4] = 4'hC;
        step("err");
        din[4] = 4'd2;
        total++;
        if (err !== 1'b1) begin
            bad++;
            $display("FAIL err_set got=%b want=1", err);
        end
        repeat (17) step("err");
        total++;
        if (seg !== 7'h40 || dig_en !== 6'b010000) begin
            bad++;
            $display("FAIL err_dash got=%h/%b want=40/010000", seg, dig_en);
        end
        repeat (2 * FL) step("err");
        total++;
        if (err !== 1'b1) begin
            bad++;
            $display("FAIL err_sticky got=%b want=1", err);
        end
    endtask

    task automatic test_reset_midscan();
        while (cyc % FL != 13) step("pre_rst");
        #2;
        reset_n = 1'b0;
        #1;
        check_zero("reset_mid");
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        step("post_rst");
        total++;
        if (dig_en !== 6'b000001 || seg !== 7'h3F || err !== 1'b0) begin
            bad++;
            $display("FAIL post_rst got=%b/%h/%b want=000001/3f/0", dig_en, seg, err);
        end
        repeat (2 * FL) step("post_rst");
    endtask

    initial begin
        model_reset();
        test_reset();
        test_first_frame();
        test_midframe();
        test_no_blank();
        test_set_blink();
        test_err();
        test_reset_midscan();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/watch_display_scan.md
Name: watch_display_scan

Overview:
- Downstream consumer of the watch counter's six BCD output digits (sec/min/hr, lsb/msb each).
- Drives a time-multiplexed six-digit common-anode-agnostic seven-segment display: one digit enabled at a time, with a registered segment pattern.
- Snapshots the digits once per scan frame so the display never shows a torn time.
- Adds a colon blink, hour leading-zero blanking, a set-mode digit blink, and a sticky error for non-BCD input.

Parameters:
- SCAN_DIV, 4, clk cycles each digit stays enabled (>=2).
- BLINK_FRAMES, 8, scan frames per set-mode blink half-period (>=1).
- LZB, 1, when 1 the hour msb digit is blanked if its value is 0.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- sec_lsb  input  4  BCD seconds units from watch
- sec_msb  input  4  BCD seconds tens
- min_lsb  input  4  BCD minutes units
- min_msb  input  4  BCD minutes tens
- hr_lsb  input  4  BCD hours units
- hr_msb  input  4  BCD hours tens
- set  input  1  watch set mode active (same signal fed to watch)
- seg  output  7  segments {g,f,e,d,c,b,a}, active-high
- dig_en  output  6  one-hot digit enable; bit0=sec_lsb ... bit5=hr_msb
- colon  output  1  colon segment, active-high
- err  output  1  sticky: a non-BCD digit (>9) was snapshotted

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values (asynchronous):
  - prescaler pre=0, index idx=0, frame counter=0, blink_phase=0.
  - shadow digits all 0.
  - seg=0, dig_en=0, colon=0, err=0.
- Prescaler: pre counts 0..SCAN_DIV-1 and wraps.
  - At pre==SCAN_DIV-1, idx advances 0..5 and wraps 5->0.
  - Frame length is 6*SCAN_DIV cycles.
- Snapshot:
  - set=0: all six inputs load into the shadow register only on the cycle where pre==SCAN_DIV-1 and idx==5 (frame boundary).
  - set=1: the shadow loads every cycle.
- Blink:
  - On each frame boundary the frame counter increments.
  - At BLINK_FRAMES-1 the frame counter wraps to 0 and blink_phase toggles.
  - The counter runs regardless of set.
- Output register: updated every cycle from the current idx and shadow, giving 1-cycle latency.
  - dig_en <= onehot(idx), except dig_en <= 0 when set=1 and blink_phase=1.
  - dig_en is also 0 for idx==5 when LZB=1 and shadow hr_msb==0.
  - seg <= decode(shadow[idx]). Hex values: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Any value 10..15 decodes to 40 (dash).
  - seg keeps its decoded value even when the digit is blanked; only dig_en gates it.
  - colon <= ~shadow sec_lsb[0], i.e. on during even seconds. colon is not affected by the set blink.
- Error:
  - err is set on any shadow load where any loaded digit >9.
  - It is cleared only by reset.
- Boundary conditions:
  - set rising mid-frame: the shadow updates the very next cycle; scan position is undisturbed.
  - set falling: the shadow freezes until the next frame boundary.
  - Reset mid-frame: all state returns to reset values immediately.
  - After reset release, the first edge gives dig_en=000001 and seg=3F.
  - Input changes between frame boundaries (set=0) are invisible until the next boundary.

Test Plan:
- Reset then run, inputs 03:45:53, set=0, SCAN_DIV=4:
  - First frame shows zeros: cycle 1 gives dig_en=000001, seg=3F, and hr_msb is blanked.
  - After cycle 24 the shadow holds 03:45:53.
  - Next frame: digit0 seg=4F, digit1 seg=6D, digit5 blanked (LZB), colon=0 (sec 3 odd).
- Input sec_lsb changes 3->4 at mid-frame, set=0:
  - Displayed digit0 stays 4F until the frame boundary, then shows 66.
  - colon becomes 1.
- Inputs 23:59:55:
  - digit5 dig_en=100000 with seg=5B (not blanked), digit4 seg=4F.
  - Scan order bit0->bit5 repeats every 24 cycles.
- set=1 for 20 frames with inputs 06:58:55:
  - Shadow tracks inputs each cycle.
  - dig_en=0 for 8-frame stretches alternating with normal scanning.
  - colon unaffected.
- hr_lsb=4'hC on a frame boundary: digit4 seg=40, err=1 and remains 1 after inputs return to valid BCD.
- Assert reset_n=0 mid-scan (idx=3): seg, dig_en, colon and err go to 0 asynchronously; scan restarts at bit0 after release.
